// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = (A - B - Bin) mod 2^WIDTH, one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   sa, sb, wr;
  logic               br;
  logic [CNT_W-1:0]   cnt;

  logic               d_bit;
  logic               br_next;
  logic               last_bit;
  logic [WIDTH-1:0]   wr_next;

  // Full-subtractor cell on the current LSBs
  assign d_bit    = sa[0] ^ sb[0] ^ br;
  assign br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign wr_next  = {d_bit, wr[WIDTH-1:1]};

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      wr   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= A;
            sb  <= B;
            br  <= Bin;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_next;
          wr  <= wr_next;
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            diff <= wr_next;
            bout <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit sa[0]/sb[0] hold the original operand MSBs
            ovf  <= (sa[0] ^ sb[0]) & (sa[0] ^ d_bit);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
